// File: rtl/rej_uniform_stream.sv
// rej_uniform_stream
// Sequential rejection sampler for one polynomial. It takes 3-byte XOF beats,
// unpacks candidate coefficients (two 12-bit candidates per beat for ML-KEM,
// one 23-bit candidate for ML-DSA) and keeps only candidates below the
// modulus. Kept candidates are emitted with their index until NUM_COEFFS
// coefficients have been produced.
//
// Ports
//   clk_i, rst_i         clock; synchronous active-high reset
//   start_i, mode_i      start a run (IDLE only); 0 = ML-KEM, 1 = ML-DSA
//   in_valid_i/in_ready_o/in_data_i     XOF beat stream {b2,b1,b0}
//   out_valid_o/out_ready_i/out_data_o/out_idx_o   coefficient stream
//   busy_o               state != IDLE
//   done_o               one-cycle pulse after the final output transfer
//   reject_cnt_o         saturating reject count for the current run
module rej_uniform_stream #(
  parameter int NUM_COEFFS = 256,
  parameter int KYBER_Q    = 3329,
  parameter int DIL_Q      = 8380417,
  parameter int OUT_W      = 24,
  parameter int IDX_W      = $clog2(NUM_COEFFS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [23:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      reject_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [22:0]      KQ       = 23'(KYBER_Q);
  localparam logic [22:0]      DQ       = 23'(DIL_Q);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [22:0]      slot0_q, slot0_d, slot1_q, slot1_d;
  logic             slot0_v_q, slot0_v_d, slot1_v_q, slot1_v_d;
  logic [IDX_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [22:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [15:0]      rej_cnt_q, rej_cnt_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;

  logic             beat_fire_s;
  logic             out_fire_s;
  logic             head_ok_s;
  logic             can_load_s;
  logic [22:0]      q_sel_s;

  assign beat_fire_s = in_valid_i & in_ready_q;
  assign out_fire_s  = out_valid_q & out_ready_i;
  assign q_sel_s     = mode_q ? DQ : KQ;
  assign head_ok_s   = slot0_q < q_sel_s;
  // The output register can take a new value when empty or emptying this cycle.
  assign can_load_s  = ~out_valid_q | out_ready_i;

  // Next-state logic: run control, slot pipeline, output register, counters.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    slot0_v_d   = slot0_v_q;
    slot1_v_d   = slot1_v_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rej_cnt_d   = rej_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          mode_d    = mode_i;
          acc_cnt_d = '0;
          rej_cnt_d = 16'h0000;
          slot0_v_d = 1'b0;
          slot1_v_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (out_fire_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (slot0_v_q) begin
          if (!head_ok_s) begin
            if (rej_cnt_q != 16'hFFFF) begin
              rej_cnt_d = rej_cnt_q + 16'h0001;
            end else begin
              rej_cnt_d = rej_cnt_q;
            end
            slot0_d   = slot1_q;
            slot0_v_d = slot1_v_q;
            slot1_v_d = 1'b0;
          end else if (can_load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = slot0_q;
            out_idx_d   = acc_cnt_q;
            acc_cnt_d   = acc_cnt_q + IDX_W'(1);
            slot0_d     = slot1_q;
            slot0_v_d   = slot1_v_q;
            slot1_v_d   = 1'b0;
            // Last coefficient loaded: whatever is still queued is discarded.
            if (acc_cnt_q == LAST_IDX) begin
              state_d   = DRAIN;
              slot0_v_d = 1'b0;
              slot1_v_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end else begin
            slot0_v_d = slot0_v_q;
          end
        end else if (beat_fire_s) begin
          // A beat is only accepted while both slots are empty.
          if (!mode_q) begin
            slot0_d   = {11'd0, in_data_i[11:0]};
            slot1_d   = {11'd0, in_data_i[23:12]};
            slot0_v_d = 1'b1;
            slot1_v_d = 1'b1;
          end else begin
            slot0_d   = in_data_i[22:0];
            slot0_v_d = 1'b1;
            slot1_v_d = 1'b0;
          end
        end else begin
          slot0_v_d = slot0_v_q;
        end
      end
      DRAIN: begin
        if (out_fire_s) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          done_d      = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        slot0_v_d   = 1'b0;
        slot1_v_d   = 1'b0;
      end
    endcase

    // Ready is decoded from next state so the port is driven by a flop.
    in_ready_d = (state_d == RUN) & ~slot0_v_d & ~slot1_v_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      slot0_q     <= 23'd0;
      slot1_q     <= 23'd0;
      slot0_v_q   <= 1'b0;
      slot1_v_q   <= 1'b0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 23'd0;
      out_idx_q   <= '0;
      rej_cnt_q   <= 16'h0000;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      slot0_v_q   <= slot0_v_d;
      slot1_v_q   <= slot1_v_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rej_cnt_q   <= rej_cnt_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = OUT_W'(out_data_q);
  assign out_idx_o    = out_idx_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign reject_cnt_o = rej_cnt_q;

endmodule

// File: tb/tb_rej_uniform_stream.sv
module tb_rej_uniform_stream;

  localparam int N     = 3;
  localparam int IDX_W = $clog2(N);
  localparam int KQ    = 3329;
  localparam int DQ    = 8380417;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [23:0]      in_data_i = 24'h0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [23:0]      out_data_o;
  logic [IDX_W-1:0] out_idx_o;
  logic             busy_o;
  logic             done_o;
  logic [15:0]      reject_cnt_o;

  rej_uniform_stream #(.NUM_COEFFS(N), .OUT_W(24)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o),
    .busy_o(busy_o), .done_o(done_o), .reject_cnt_o(reject_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected (value, index) pairs and reject count.
  int exp_data[$];
  int exp_idx[$];
  int got_data[$];
  int got_idx[$];
  int model_acc = 0;
  int model_rej = 0;
  bit model_mode = 1'b0;
  int done_pulses = 0;

  bit prev_stall = 1'b0;
  bit prev_final = 1'b0;
  int prev_data = 0;
  int prev_idx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply the sampling rules to one beat at the candidate level.
  task automatic model_apply(input logic [23:0] d);
    int cand[$];
    int q;
    if (!model_mode) begin
      cand.push_back(int'(d[11:0]));
      cand.push_back(int'(d[23:12]));
      q = KQ;
    end else begin
      cand.push_back(int'(d[22:0]));
      q = DQ;
    end
    foreach (cand[k]) begin
      if (model_acc < N) begin
        if (cand[k] < q) begin
          exp_data.push_back(cand[k]);
          exp_idx.push_back(model_acc);
          model_acc++;
        end else if (model_rej < 65535) begin
          model_rej++;
        end
      end
    end
  endtask

  // Output monitor: every transfer, hold-under-stall and done pulse timing.
  always @(negedge clk) begin
    bit fin;
    fin = 1'b0;
    if (rst_i) begin
      prev_stall = 1'b0;
      prev_final = 1'b0;
    end else begin
      chk("done_timing", done_o, prev_final);
      if (done_o) done_pulses++;
      if (prev_final) chk("busy_after_done", busy_o, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid_o, 1);
        chk("stall_data", out_data_o, prev_data);
        chk("stall_idx", out_idx_o, prev_idx);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_output", out_data_o, -1);
        end else begin
          chk("out_data", out_data_o, exp_data[0]);
          chk("out_idx", out_idx_o, exp_idx[0]);
          fin = (exp_idx[0] == N - 1);
          got_data.push_back(int'(out_data_o));
          got_idx.push_back(int'(out_idx_o));
          void'(exp_data.pop_front());
          void'(exp_idx.pop_front());
        end
      end
      prev_final = fin;
      prev_stall = out_valid_o && !out_ready_i;
      prev_data = int'(out_data_o);
      prev_idx = int'(out_idx_o);
    end
  end

  task automatic do_reset(input bit check_zero);
    @(negedge clk);
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_zero) begin
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_out_idx", out_idx_o, 0);
      chk("rst_reject_cnt", reject_cnt_o, 0);
    end
    exp_data.delete();
    exp_idx.delete();
    got_data.delete();
    got_idx.delete();
    model_acc = 0;
    model_rej = 0;
    rst_i = 1'b0;
  endtask

  task automatic do_start(input bit m);
    @(negedge clk);
    start_i = 1'b1;
    mode_i = m;
    model_mode = m;
    model_acc = 0;
    model_rej = 0;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_in_run", busy_o, 1);
  endtask

  task automatic send_beat(input logic [23:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i = d;
    for (int i = 0; i < 100; i++) begin
      if (in_ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    chk("beat_accept", ok, 1);
    if (ok) model_apply(d);
  endtask

  task automatic wait_drain(input int rej_literal);
    for (int i = 0; i < 60 && exp_data.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("outputs_drained", exp_data.size(), 0);
    chk("reject_cnt_model", reject_cnt_o, model_rej);
    chk("reject_cnt_literal", reject_cnt_o, rej_literal);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_valid_seen", seen, 1);
  endtask

  initial begin
    // Reset state.
    do_reset(1'b1);

    // ML-KEM 24'h456123 -> 291 @0, 1110 @1; first output one edge after accept.
    do_start(1'b0);
    send_beat(24'h456123);
    chk("lat_not_yet", out_valid_o, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid_o, 1);
    chk("lat_data", out_data_o, 291);
    wait_drain(0);
    chk("pin_c0", (got_data.size() > 0) ? got_data[0] : -1, 291);
    chk("pin_c1", (got_data.size() > 1) ? got_data[1] : -1, 1110);
    chk("pin_idx1", (got_idx.size() > 1) ? got_idx[1] : -1, 1);

    // ML-KEM boundary: 3328 accepted, 3329 rejected.
    do_reset(1'b0);
    do_start(1'b0);
    send_beat(24'hD01D00);
    wait_drain(1);
    chk("pin_3328", (got_data.size() > 0) ? got_data[0] : -1, 3328);
    chk("count_3328", got_data.size(), 1);

    // ML-DSA: two rejects (bit 23 masked, q itself) then q-1 at index 0.
    do_reset(1'b0);
    do_start(1'b1);
    send_beat(24'hFFFFFF);
    send_beat(24'h7FE001);
    send_beat(24'h7FE000);
    wait_drain(2);
    chk("pin_dsa", (got_data.size() > 0) ? got_data[0] : -1, 8380416);
    chk("pin_dsa_idx", (got_idx.size() > 0) ? got_idx[0] : -1, 0);

    // Backpressure with c1 pending for 10 cycles.
    do_reset(1'b0);
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    do_start(1'b0);
    send_beat(24'h456123);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", out_data_o, 291);
      chk("bp_idx", out_idx_o, 0);
      chk("bp_in_ready", in_ready_o, 0);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    wait_drain(0);
    chk("bp_count", got_data.size(), 2);

    // Full run of N=3: 291,1110,291; fourth candidate flushed; done pulse.
    do_reset(1'b0);
    done_pulses = 0;
    do_start(1'b0);
    send_beat(24'h456123);
    send_beat(24'h456123);
    wait_drain(0);
    chk("full_count", got_data.size(), 3);
    chk("pin_full2", (got_data.size() > 2) ? got_data[2] : -1, 291);
    chk("pin_full_idx2", (got_idx.size() > 2) ? got_idx[2] : -1, 2);
    chk("done_pulses", done_pulses, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_in_ready", in_ready_o, 0);
    chk("idle_out_valid", out_valid_o, 0);

    // Reset mid-run with a coefficient held in the output register.
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    do_start(1'b0);
    send_beat(24'h456123);
    wait_valid();
    do_reset(1'b1);
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    do_start(1'b0);
    send_beat(24'hD01D00);
    wait_drain(1);
    chk("after_rst_data", (got_data.size() > 0) ? got_data[0] : -1, 3328);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
